// File: rtl/key_step_pulser.sv
// key_step_pulser: sync, debounce and auto-repeat for an active-low key.
// Emits one-cycle step pulses for the counter's T input.
module key_step_pulser #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic clear,
  input  logic key_n,
  input  logic enable_in,
  output logic step,
  output logic pressed,
  output logic repeating
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD)
                      ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW = $clog2(TMAX);

  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HLAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RLAST = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  logic          s1_q, s2_q;
  logic [DW-1:0] db_q, db_d;
  logic          pressed_q, pressed_d;
  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          step_q, step_d;
  logic          rep_q, rep_d;
  logic          lvl;
  logic          pulse;

  assign lvl = ~s2_q;

  always_comb begin
    db_d      = db_q;
    pressed_d = pressed_q;
    if (lvl == pressed_q) begin
      db_d = '0;
    end else if (db_q == DLAST) begin
      pressed_d = lvl;
      db_d      = '0;
    end else begin
      db_d = db_q + 1'b1;
    end
  end

  // Decisions use the new debounced level so a release
  // on a would-be pulse edge suppresses that pulse.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pulse   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pressed_d) begin
          pulse   = 1'b1;
          tmr_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!pressed_d) begin
          tmr_d   = '0;
          state_d = IDLE;
        end else if (tmr_q == HLAST) begin
          pulse   = 1'b1;
          tmr_d   = '0;
          state_d = REPEAT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!pressed_d) begin
          tmr_d   = '0;
          state_d = IDLE;
        end else if (tmr_q == RLAST) begin
          pulse = 1'b1;
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        tmr_d   = '0;
        state_d = IDLE;
      end
    endcase
    step_d = pulse & enable_in;
    rep_d  = (state_d == REPEAT);
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      db_q      <= '0;
      pressed_q <= 1'b0;
      state_q   <= IDLE;
      tmr_q     <= '0;
      step_q    <= 1'b0;
      rep_q     <= 1'b0;
    end else begin
      s1_q      <= key_n;
      s2_q      <= s1_q;
      db_q      <= db_d;
      pressed_q <= pressed_d;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      step_q    <= step_d;
      rep_q     <= rep_d;
    end
  end

  assign step      = step_q;
  assign pressed   = pressed_q;
  assign repeating = rep_q;

endmodule

// File: tb/tb_key_step_pulser.sv
// tb_key_step_pulser: directed plus random stimulus against a
// cycle-count model of debounce and press/repeat timing.
module tb_key_step_pulser;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic clk = 1'b0;
  logic clear, key_n, enable_in;
  logic step, pressed, repeating;

  int n_cmp = 0;
  int n_bad = 0;

  key_step_pulser #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .clear(clear),
    .key_n(key_n),
    .enable_in(enable_in),
    .step(step),
    .pressed(pressed),
    .repeating(repeating)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d @%0t",
               name, act, exp, $time);
    end
  endtask

  // Model: key delayed two samples, level accepted after D
  // consecutive disagreeing samples, steps keyed off hold age.
  bit kd1, kd2, mp, mstep, mrep, mvalid;
  int run, age;

  always @(posedge clk) begin
    bit lvl, rose, pul;
    if (!clear) begin
      kd1 = 1'b1; kd2 = 1'b1;
      run = 0; age = 0;
      mp = 1'b0; mstep = 1'b0; mrep = 1'b0;
    end else begin
      lvl = !kd2;
      kd2 = kd1;
      kd1 = key_n;
      rose = 1'b0;
      if (lvl != mp) begin
        run++;
        if (run == D) begin
          mp = lvl;
          run = 0;
          rose = mp;
        end
      end else begin
        run = 0;
      end
      if (rose) age = 0;
      else if (mp) age++;
      pul = mp && (age == 0 ||
            (age >= RD && (age - RD) % RP == 0));
      mstep = pul && enable_in;
      mrep  = mp && (age >= RD);
    end
    mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("step", step, mstep);
      check("pressed", pressed, mp);
      check("repeating", repeating, mrep);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pressed && n < 60);
  endtask

  int n, rise, fall, cnt, len;
  int offs[$];
  int exp_off[9] = '{0, 8, 12, 16, 20, 24, 28, 32, 36};

  initial begin
    clear = 1'b0; key_n = 1'b0; enable_in = 1'b1;

    cyc(3);
    check("rst_pressed", pressed, 0);
    check("rst_step", step, 0);
    check("rst_rep", repeating, 0);
    clear = 1'b1;
    wait_rise(n);
    check("rst_rise_edge", n, 6);
    check("rst_press_step", step, 1);
    key_n = 1'b1;
    cyc(20);

    key_n = 1'b0;
    rise = -1; fall = -1; cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 5) key_n = 1'b1;
      if (pressed && rise < 0) rise = i;
      if (!pressed && rise >= 0 && fall < 0) fall = i;
      if (step) cnt++;
    end
    check("clean_rise", rise, 6);
    check("clean_fall", fall, 11);
    check("clean_steps", cnt, 1);

    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      key_n = ((i / 2) % 2) != 0;
      @(negedge clk);
      if (step) cnt++;
    end
    check("bounce_nostep", cnt, 0);
    key_n = 1'b0;
    wait_rise(n);
    check("bounce_rise", n, 6);
    check("bounce_step", step, 1);
    key_n = 1'b1;
    cyc(20);

    key_n = 1'b0;
    wait_rise(n);
    offs.delete();
    if (step) offs.push_back(0);
    for (int t = 1; t < 40; t++) begin
      @(negedge clk);
      if (step) offs.push_back(t);
      if (t == 7) check("rep_before", repeating, 0);
      if (t == 8) check("rep_at8", repeating, 1);
    end
    check("rep_count", offs.size(), 9);
    foreach (offs[k])
      if (k < 9) check("rep_offset", offs[k], exp_off[k]);
    key_n = 1'b1;
    cyc(20);
    check("rep_released", repeating, 0);
    check("rep_nostep", step, 0);

    enable_in = 1'b0;
    key_n = 1'b0;
    wait_rise(n);
    check("gate_step0", step, 0);
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      if (t == 8) begin
        check("gate_step8", step, 0);
        check("gate_rep8", repeating, 1);
        enable_in = 1'b1;
      end
      if (t == 12) check("gate_step12", step, 1);
    end
    key_n = 1'b1;
    cyc(20);

    key_n = 1'b0;
    wait_rise(n);
    for (int t = 1; t <= 10; t++) @(negedge clk);
    check("mid_rep10", repeating, 1);
    clear = 1'b0;
    @(negedge clk);
    check("mid_pressed", pressed, 0);
    check("mid_step", step, 0);
    check("mid_rep", repeating, 0);
    clear = 1'b1;
    wait_rise(n);
    check("mid_rise", n, 6);
    check("mid_step_after", step, 1);
    key_n = 1'b1;
    cyc(20);

    for (int s = 0; s < 300; s++) begin
      key_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(20, 60);
      else len = $urandom_range(1, 8);
      repeat (len) begin
        enable_in = ($urandom_range(0, 3) != 0);
        clear = ($urandom_range(0, 199) != 0);
        @(negedge clk);
      end
    end
    clear = 1'b1; key_n = 1'b1; enable_in = 1'b1;
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
